// File: rtl/adc_capture_pkg.sv
// Shared types and default constants for the multi-channel ADC capture block.
package adc_capture_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cap_state_e;

  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_CNT_W      = 16;
  localparam int MIN_DIV        = 2;

endpackage

// File: rtl/adc_sample_fifo.sv
// First-word-fall-through sample buffer; rdata reads as zero while empty.
module adc_sample_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk_60m,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_60m) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adc_capture_multi.sv
// Multi-channel ADC capture: divided adc_clk, per-period sample capture and FWFT output buffer.
//   state   | meaning
//   ST_IDLE | divider parked at 0, adc_clk low, waiting for start
//   ST_RUN  | divider running, one capture per adc_clk period until stop or burst end
module adc_capture_multi
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                           clk_60m,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic [CNT_W-1:0]               div_n,
  input  logic [CNT_W-1:0]               burst_len,
  input  logic                           test_mode,
  input  logic [NUM_CH*DATA_W-1:0]       adc_data,
  input  logic [NUM_CH-1:0]              adc_otr,
  output logic                           adc_clk,
  output logic [NUM_CH*(DATA_W+1)-1:0]   m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int WORD_W = NUM_CH * (DATA_W + 1);

  cap_state_e        state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [CNT_W-1:0]  d_q, blen_q, burst_cnt_q, half;
  logic              tmode_q;
  logic [DATA_W-1:0] test_cnt_q;
  logic [WORD_W-1:0] samp_q, cap_word;
  logic              wr_pend_q;
  logic              start_acc, cap_now, wr_now, burst_end;
  logic              fifo_full, fifo_empty;

  assign half      = d_q >> 1;
  assign start_acc = (state_q == ST_IDLE) && start && !stop;
  assign cap_now   = (state_q == ST_RUN) && !stop && (cnt_q == half - 1'b1);
  // Stop on the write edge drops the pending sample.
  assign wr_now    = (state_q == ST_RUN) && wr_pend_q && !stop;
  assign burst_end = wr_now && (blen_q != '0) && (burst_cnt_q == blen_q - 1'b1);

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (start && !stop)       state_nxt = ST_RUN;
      ST_RUN:  if (stop || burst_end)    state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
  end

  always_comb begin
    cnt_nxt = '0;
    if (state_q == ST_RUN && state_nxt == ST_RUN)
      cnt_nxt = (cnt_q == d_q - 1'b1) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    cap_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tmode_q)
        cap_word[k*(DATA_W+1) +: (DATA_W+1)] = {1'b0, test_cnt_q + DATA_W'(k)};
      else
        cap_word[k*(DATA_W+1) +: (DATA_W+1)] = {adc_otr[k], adc_data[k*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      adc_clk     <= 1'b0;
      d_q         <= CNT_W'(MIN_DIV);
      blen_q      <= '0;
      tmode_q     <= 1'b0;
      test_cnt_q  <= '0;
      samp_q      <= '0;
      wr_pend_q   <= 1'b0;
      burst_cnt_q <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      cnt_q   <= cnt_nxt;
      // On start cnt_nxt is 0 and half >= 1, so the stale divisor is harmless here.
      adc_clk <= (state_nxt == ST_RUN) && (cnt_nxt >= half);
      done    <= burst_end;
      if (start_acc) begin
        d_q         <= (div_n < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_n;
        blen_q      <= burst_len;
        tmode_q     <= test_mode;
        test_cnt_q  <= '0;
        burst_cnt_q <= '0;
        overflow    <= 1'b0;
      end else begin
        if (cap_now) begin
          samp_q     <= cap_word;
          test_cnt_q <= test_cnt_q + 1'b1;
        end
        if (wr_now) begin
          burst_cnt_q <= burst_cnt_q + 1'b1;
          if (fifo_full && !m_ready) overflow <= 1'b1;
        end
      end
      if (state_nxt != ST_RUN) wr_pend_q <= 1'b0;
      else if (cap_now)        wr_pend_q <= 1'b1;
      else if (wr_now)         wr_pend_q <= 1'b0;
    end
  end

  adc_sample_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_60m (clk_60m),
    .rst_n   (rst_n),
    .push    (wr_now),
    .wdata   (samp_q),
    .pop     (m_valid && m_ready),
    .rdata   (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_adc_capture_multi.sv
// Scoreboard bench for adc_capture_multi with default parameters (2 ch x 12 bit, 16-deep buffer).
module tb_adc_capture_multi;

  logic        clk_60m = 1'b0;
  logic        rst_n;
  logic        start, stop, test_mode, m_ready;
  logic [15:0] div_n, burst_len;
  logic [23:0] adc_data;
  logic [1:0]  adc_otr;
  logic        adc_clk, m_valid, busy, done, overflow;
  logic [25:0] m_data;

  int n_vec  = 0;
  int n_miss = 0;
  logic [25:0] exp_q[$];

  adc_capture_multi dut (
    .clk_60m   (clk_60m),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .div_n     (div_n),
    .burst_len (burst_len),
    .test_mode (test_mode),
    .adc_data  (adc_data),
    .adc_otr   (adc_otr),
    .adc_clk   (adc_clk),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk_60m = ~clk_60m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] tc_word(input int i);
    logic [11:0] d0, d1;
    d0 = 12'(i);
    d1 = 12'(i + 1);
    return {1'b0, d1, 1'b0, d0};
  endfunction

  // Output side of the scoreboard: every accepted word must match the oldest expectation.
  always @(negedge clk_60m) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("sb_underrun", 64'(exp_q.size()), 64'(1));
      else                   chk("word", 64'(m_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk_60m);
    #1;
  endtask

  task automatic start_cap(input logic [15:0] d, input logic [15:0] bl, input logic tm);
    div_n = d; burst_len = bl; test_mode = tm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic scan(input int n, output int rise1, output int period, output int high_n,
                      output int done_at, output int done_n);
    logic prev;
    int   rise2;
    rise1 = -1; rise2 = -1; high_n = 0; done_at = -1; done_n = 0; prev = adc_clk;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (adc_clk && !prev) begin
        if (rise1 < 0)      rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      if (rise1 >= 0 && rise2 < 0 && adc_clk) high_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      prev = adc_clk;
    end
    period = (rise1 >= 0 && rise2 >= 0) ? rise2 - rise1 : -1;
  endtask

  initial begin
    int r1, per, hi, d_at, d_n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; test_mode = 1'b0; m_ready = 1'b0;
    div_n = '0; burst_len = '0; adc_data = '0; adc_otr = '0;
    #2;
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_mdata", 64'(m_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_adcclk", 64'(adc_clk), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1; div_n = 16'd4; burst_len = 16'd1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_wins_busy", 64'(busy), 64'(0));
    tick();

    // div 30, burst 4, test pattern
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(tc_word(i));
    start_cap(16'd30, 16'd4, 1'b1);
    chk("t1_busy", 64'(busy), 64'(1));
    scan(130, r1, per, hi, d_at, d_n);
    chk("t1_rise", 64'(r1), 64'(15));
    chk("t1_period", 64'(per), 64'(30));
    chk("t1_high", 64'(hi), 64'(15));
    chk("t1_done_at", 64'(d_at), 64'(106));
    chk("t1_done_n", 64'(d_n), 64'(1));
    chk("t1_busy_end", 64'(busy), 64'(0));
    chk("t1_drained", 64'(exp_q.size()), 64'(0));

    // div 0 clamps to 2
    for (int i = 0; i < 4; i++) exp_q.push_back(tc_word(i));
    start_cap(16'd0, 16'd4, 1'b1);
    scan(20, r1, per, hi, d_at, d_n);
    chk("t2_rise", 64'(r1), 64'(1));
    chk("t2_period", 64'(per), 64'(2));
    chk("t2_high", 64'(hi), 64'(1));
    chk("t2_done_at", 64'(d_at), 64'(8));
    chk("t2_done_n", 64'(d_n), 64'(1));
    chk("t2_drained", 64'(exp_q.size()), 64'(0));

    // continuous, output stalled: 16 kept, 17th dropped
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(tc_word(i));
    start_cap(16'd2, 16'd0, 1'b1);
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i == 33) chk("t3_ovf_pre", 64'(overflow), 64'(0));
      if (i == 34) chk("t3_ovf_set", 64'(overflow), 64'(1));
    end
    repeat (6) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_busy_stop", 64'(busy), 64'(0));
    chk("t3_ovf_sticky", 64'(overflow), 64'(1));
    m_ready = 1'b1;
    repeat (20) tick();
    chk("t3_drained", 64'(exp_q.size()), 64'(0));
    chk("t3_empty", 64'(m_valid), 64'(0));
    exp_q.push_back(tc_word(0));
    start_cap(16'd2, 16'd1, 1'b1);
    chk("t3_ovf_clr", 64'(overflow), 64'(0));
    repeat (8) tick();
    chk("t3b_drained", 64'(exp_q.size()), 64'(0));

    // stop mid-burst with a third sample pending
    m_ready = 1'b0;
    exp_q.push_back(tc_word(0));
    exp_q.push_back(tc_word(1));
    start_cap(16'd4, 16'd10, 1'b1);
    for (int i = 1; i <= 10; i++) tick();
    chk("t4_clk_hi", 64'(adc_clk), 64'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_clk_lo", 64'(adc_clk), 64'(0));
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_done", 64'(done), 64'(0));
    scan(20, r1, per, hi, d_at, d_n);
    chk("t4_done_n", 64'(d_n), 64'(0));
    m_ready = 1'b1;
    repeat (6) tick();
    chk("t4_drained", 64'(exp_q.size()), 64'(0));
    chk("t4_empty", 64'(m_valid), 64'(0));

    // reset mid-burst with 3 words buffered
    m_ready = 1'b0;
    start_cap(16'd2, 16'd10, 1'b1);
    for (int i = 1; i <= 6; i++) tick();
    chk("t5_valid_pre", 64'(m_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(m_valid), 64'(0));
    chk("t5_mdata", 64'(m_data), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_adcclk", 64'(adc_clk), 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    chk("t5_ovf", 64'(overflow), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_valid_post", 64'(m_valid), 64'(0));

    // real data with over-range on channel 1
    m_ready = 1'b1;
    adc_data = {12'hFFF, 12'h123};
    adc_otr = 2'b10;
    exp_q.push_back({1'b1, 12'hFFF, 1'b0, 12'h123});
    start_cap(16'd4, 16'd1, 1'b0);
    scan(10, r1, per, hi, d_at, d_n);
    chk("t6_done_at", 64'(d_at), 64'(3));
    chk("t6_done_n", 64'(d_n), 64'(1));
    chk("t6_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adc_capture_multi.md
ADC_CAPTURE_MULTI -- requirements
Module: adc_capture_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of parallel ADC channels (1..4).
REQ-002 SHALL have parameter DATA_W, default 12: ADC sample width per channel.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: output buffer entries (power of 2, >=4).
REQ-004 SHALL have parameter CNT_W, default 16: width of the divider and burst-length fields.
REQ-005 SHALL have port clk_60m, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that arms a capture.
REQ-008 SHALL have port stop, input, 1: one-cycle pulse that aborts a capture.
REQ-009 SHALL have port div_n, input, CNT_W: ADC clock divisor, latched at start.
REQ-010 SHALL have port burst_len, input, CNT_W: samples per capture, latched at start; 0 means continuous.
REQ-011 SHALL have port test_mode, input, 1: selects the counter pattern, latched at start.
REQ-012 SHALL have port adc_data, input, NUM_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port adc_otr, input, NUM_CH: per-channel over-range.
REQ-014 SHALL have port adc_clk, output, 1: divided ADC clock shared by all channels.
REQ-015 SHALL have port m_data, output, NUM_CH*(DATA_W+1): entry {otr[k], data[k]} per channel, channel 0 in the LSBs.
REQ-016 SHALL have ports m_valid (output, 1) and m_ready (input, 1): stream handshake.
REQ-017 SHALL have ports busy, done and overflow, each an output of width 1.

Function
REQ-018 SHALL run the FSM IDLE->RUN on start, and RUN->IDLE on stop or when the burst count reaches burst_len (burst_len!=0).
REQ-019 SHALL ignore start while in RUN; if stop and start arrive in the same IDLE cycle, stop wins.
REQ-020 SHALL clamp the latched divisor to 2 when div_n<2.
REQ-021 SHALL run divider counter cnt from 0 to D-1 and wrap, only in RUN; cnt SHALL be held at 0 in IDLE.
REQ-022 SHALL drive adc_clk = (RUN && cnt >= D>>1) from a register, and SHALL drive it low in IDLE.
REQ-023 SHALL register all channels' data and otr together at the edge where cnt==(D>>1)-1, which is the last low cycle before the adc_clk rise.
REQ-024 SHALL write the captured word into the FIFO on the following edge; m_valid SHALL be high no later than the next edge.
REQ-025 SHALL make the FIFO first-word-fall-through: m_data is valid whenever m_valid=1, and a pop occurs on an edge with m_valid && m_ready.
REQ-026 SHALL, when the FIFO is full at write time, drop the word, set overflow (sticky), and still count the sample towards the burst.
REQ-027 SHALL allow a simultaneous push and pop at full: the pop frees the slot, so no overflow occurs.
REQ-028 SHALL clear overflow only on an accepted start or on reset.
REQ-029 SHALL, in test mode, set channel k data = (test_cnt + k) mod 2^DATA_W and otr=0; test_cnt SHALL clear on start and increment once after each capture.
REQ-030 SHALL pulse done for 1 cycle when a burst completes, on the cycle the FSM enters IDLE; done SHALL NOT pulse on stop.
REQ-031 SHALL, on stop, go to IDLE on the next edge and drop any sample captured but not yet written.
REQ-032 SHALL retain the FIFO contents on stop and keep them drainable.
REQ-033 SHALL drive busy = (state==RUN).

Reset
REQ-034 SHALL, on rst_n low, asynchronously set state=IDLE, cnt=0, adc_clk=0, the FIFO empty (m_valid=0), m_data=0, busy=0, done=0, overflow=0, test_cnt=0, and the latched config to D=2, burst_len=0, test_mode=0.
REQ-035 SHALL, on reset mid-capture, discard all buffered samples.

Structure
REQ-036 SHALL place the FSM state enum and the default parameter constants in the shared package adc_capture_pkg.
REQ-037 SHALL implement the buffer as sub-module adc_sample_fifo, parametrised by width and depth, with full/empty flags and FWFT output.

Verification
REQ-038 SHALL cover: div_n=30, burst_len=4, test_mode=1, NUM_CH=2, m_ready=1 -> adc_clk period 30 cycles, high for 15; words ch0/ch1 = 0/1, 1/2, 2/3, 3/4; done pulses once; busy falls.
REQ-039 SHALL cover: div_n=0 -> behaves as D=2, giving a 30 MHz adc_clk and one capture every 2 cycles.
REQ-040 SHALL cover: m_ready=0, continuous mode, FIFO_DEPTH=16 -> the first 16 words are retained, the 17th is dropped, overflow=1 stays set after stop and clears on the next start.
REQ-041 SHALL cover: stop issued mid-burst at sample 2 of 10 -> adc_clk is low on the next cycle, no done pulse, and the 2 buffered words drain intact.
REQ-042 SHALL cover: rst_n asserted mid-burst with 3 words buffered -> all outputs immediately reach their reset values and m_valid=0.
REQ-043 SHALL cover: real mode with adc_otr=2'b10 and adc_data ch1=12'hFFF at the sample edge -> m_data ch1 = {1,12'hFFF}, ch0 otr=0.
